// File: rtl/engine_inv_key_generator.sv
// ---------------------------------------------------------------------------
// engine_inv_key_generator
//   Inverse AES-128 key schedule. Starting from the round-10 key, walks the
//   expansion backwards one round per step and exposes all eleven round keys
//   in parallel; round0_key is the recovered cipher key. transformer_start
//   tells the downstream inverse transformer that every key is valid.
//
// Ports
//   clk                        system clock, rising edge
//   rst_                       synchronous active-high reset
//   key_in[127:0]              round-10 key (w40 in [127:96] .. w43 in [31:0])
//   key_start                  level start request, sampled only in IDLE
//   transformer_start          high once all round keys are valid
//   round0_key..round10_key    round keys
//
// Optional build macro: INV_KEY_SBOX_REG_EN
//   When defined, a register stage follows SubWord and each backward step
//   takes two cycles instead of one. Key values are the same in both builds.
// ---------------------------------------------------------------------------
module engine_inv_key_generator (
    input  logic         clk,
    input  logic         rst_,
    input  logic [127:0] key_in,
    input  logic         key_start,
    output logic         transformer_start,
    output logic [127:0] round0_key,
    output logic [127:0] round1_key,
    output logic [127:0] round2_key,
    output logic [127:0] round3_key,
    output logic [127:0] round4_key,
    output logic [127:0] round5_key,
    output logic [127:0] round6_key,
    output logic [127:0] round7_key,
    output logic [127:0] round8_key,
    output logic [127:0] round9_key,
    output logic [127:0] round10_key
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Forward AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // (255 - x) * 8 == {~x, 3'b000}
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_round;
    logic [127:0]   r_keys [0:10];
    logic           r_ts;

    logic [127:0]   w_cur;
    logic [31:0]    w_d_n, w_c_n, w_b_n;
    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [127:0]   w_prev;
    logic           w_step_fire;

    // Backward step: recover key r-1 from key r = (a,b,c,d).
    assign w_cur = r_keys[r_round];
    assign w_d_n = w_cur[31:0]  ^ w_cur[63:32];
    assign w_c_n = w_cur[63:32] ^ w_cur[95:64];
    assign w_b_n = w_cur[95:64] ^ w_cur[127:96];
    assign w_rot = {w_d_n[23:0], w_d_n[31:24]};
    assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                    sbox(w_rot[15:8]),  sbox(w_rot[7:0])};

`ifdef INV_KEY_SBOX_REG_EN
    logic           r_phase;
    logic [31:0]    r_sub, r_dn, r_cn, r_bn;

    // Word a is still intact in r_keys[r_round] during the second cycle.
    assign w_prev      = {w_cur[127:96] ^ r_sub ^ {rcon(r_round), 24'h0},
                          r_bn, r_cn, r_dn};
    assign w_step_fire = (r_state == RUN) && r_phase;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_phase <= 1'b0;
            r_sub   <= '0;
            r_dn    <= '0;
            r_cn    <= '0;
            r_bn    <= '0;
        end else if (r_state == RUN) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_sub <= w_sub;
                r_dn  <= w_d_n;
                r_cn  <= w_c_n;
                r_bn  <= w_b_n;
            end
        end else begin
            r_phase <= 1'b0;
        end
    end
`else
    assign w_prev      = {w_cur[127:96] ^ w_sub ^ {rcon(r_round), 24'h0},
                          w_b_n, w_c_n, w_d_n};
    assign w_step_fire = (r_state == RUN);
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (key_start) w_state_nxt = RUN;
            RUN:     if (w_step_fire && r_round == 4'd1) w_state_nxt = DONE;
            DONE:    if (!key_start) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_round <= '0;
            r_ts    <= 1'b0;
            for (int unsigned i = 0; i < 11; i++) r_keys[i] <= '0;
        end else begin
            if (r_state == IDLE && key_start) begin
                r_keys[10] <= key_in;
                r_round    <= 4'd10;
                r_ts       <= 1'b0;
            end else if (w_step_fire) begin
                r_keys[r_round - 4'd1] <= w_prev;
                r_round                <= r_round - 4'd1;
                if (r_round == 4'd1) r_ts <= 1'b1;
            end
        end
    end

    assign transformer_start = r_ts;
    assign round0_key  = r_keys[0];
    assign round1_key  = r_keys[1];
    assign round2_key  = r_keys[2];
    assign round3_key  = r_keys[3];
    assign round4_key  = r_keys[4];
    assign round5_key  = r_keys[5];
    assign round6_key  = r_keys[6];
    assign round7_key  = r_keys[7];
    assign round8_key  = r_keys[8];
    assign round9_key  = r_keys[9];
    assign round10_key = r_keys[10];

endmodule

// File: tb/tb_engine_inv_key_generator.sv
// ---------------------------------------------------------------------------
// tb_engine_inv_key_generator
//   Directed and random checks of the inverse AES-128 key schedule against a
//   forward key-expansion model with an arithmetically derived S-box.
// ---------------------------------------------------------------------------
module tb_engine_inv_key_generator;

`ifdef INV_KEY_SBOX_REG_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int LAT = 10 * STEP;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_start = 1'b0;
    logic         transformer_start;
    logic [127:0] rk [0:10];

    int n_asrt = 0;
    int n_fail = 0;

    logic [7:0]   m_sbox [0:255];
    logic [127:0] m_rk   [0:10];

    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_RK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK9  = 128'hac7766f319fadc2128d12941575c006e;

    engine_inv_key_generator u_dut (
        .clk               (clk),
        .rst_              (rst_),
        .key_in            (key_in),
        .key_start         (key_start),
        .transformer_start (transformer_start),
        .round0_key        (rk[0]),
        .round1_key        (rk[1]),
        .round2_key        (rk[2]),
        .round3_key        (rk[3]),
        .round4_key        (rk[4]),
        .round5_key        (rk[5]),
        .round6_key        (rk[6]),
        .round7_key        (rk[7]),
        .round8_key        (rk[8]),
        .round9_key        (rk[9]),
        .round10_key       (rk[10])
    );

    always #5 clk = ~clk;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-128 key expansion producing all eleven round keys.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_model(input string tag);
        for (int r = 0; r < 11; r++)
            chk($sformatf("%s_rk%0d", tag, r), rk[r], m_rk[r]);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int r = 0; r < 11; r++)
            chk($sformatf("%s_rk%0d", tag, r), rk[r], 128'h0);
        chk({tag, "_ts"}, {127'h0, transformer_start}, 128'h0);
    endtask

    // From IDLE: accept key, wait (bounded) for transformer_start, check
    // latency and all keys, then return to IDLE.
    task automatic run_key(input string tag, input logic [127:0] k10);
        int cyc = 0;
        key_in = k10;
        key_start = 1'b1;
        tick();
        chk({tag, "_ts_after_accept"}, {127'h0, transformer_start}, 128'h0);
        while (!transformer_start && cyc <= LAT + 10) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 128'(cyc), 128'(LAT));
        chk_all_model(tag);
        key_start = 1'b0;
        tick();
    endtask

    initial begin
        build_sbox();

        // Reset values
        rst_ = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");

        // FIPS-197 vector with key_start held for 40 cycles and key_in
        // cleared mid-run
        model_expand(FIPS_RK0);
        chk("model_rk10", m_rk[10], FIPS_RK10);
        rst_ = 1'b0;
        key_in = FIPS_RK10;
        key_start = 1'b1;
        tick();
        chk("fips_E0_rk10", rk[10], FIPS_RK10);
        chk("fips_E0_ts", {127'h0, transformer_start}, 128'h0);
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) key_in = '0;
            tick();
            if (c <= LAT)
                chk($sformatf("fips_ts_c%0d", c), {127'h0, transformer_start},
                    128'(c == LAT));
            if (c == STEP) chk("fips_rk9_early", rk[9], FIPS_RK9);
            if (c == LAT) begin
                chk("fips_rk0", rk[0], FIPS_RK0);
                chk("fips_rk1", rk[1], FIPS_RK1);
                chk("fips_rk9", rk[9], FIPS_RK9);
            end
        end
        chk_all_model("held40");
        chk("held40_ts", {127'h0, transformer_start}, 128'h1);

        // Restart with the zero cipher key at the earliest re-accept point
        key_start = 1'b0;
        tick();
        chk("restart_idle_ts", {127'h0, transformer_start}, 128'h1);
        model_expand(128'h0);
        key_in = m_rk[10];
        key_start = 1'b1;
        tick();
        chk("restart_ts_drop", {127'h0, transformer_start}, 128'h0);
        chk("restart_rk10", rk[10], m_rk[10]);
        for (int c = 1; c <= LAT; c++) begin
            tick();
            chk($sformatf("restart_ts_c%0d", c), {127'h0, transformer_start},
                128'(c == LAT));
        end
        chk("restart_rk0_zero", rk[0], 128'h0);
        chk_all_model("restart");

        // Reset in the middle of a run
        key_start = 1'b0;
        tick();
        key_in = FIPS_RK10;
        key_start = 1'b1;
        tick();
        for (int c = 1; c < 5; c++) tick();
        rst_ = 1'b1;
        key_start = 1'b0;
        tick();
        chk_all_zero("midrun_reset");
        rst_ = 1'b0;
        for (int c = 0; c < LAT + 4; c++) begin
            tick();
            chk($sformatf("midrun_ts_quiet_c%0d", c), {127'h0, transformer_start}, 128'h0);
        end
        model_expand(FIPS_RK0);
        run_key("post_reset_fips", FIPS_RK10);

        // Random cipher keys through the forward model
        for (int n = 0; n < 8; n++) begin
            logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            run_key($sformatf("rand%0d", n), m_rk[10]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
